// File: rtl/countdown_pkg.sv
// -----------------------------------------------------------------------------
// countdown_pkg
//   Shared definitions for the countdown timer arbiter:
//     - state_t    : FSM state encoding (IDLE, LOAD, COUNT, DONE)
//     - COUNT_W    : width of the seconds counter / start value
//     - REQ_A/B    : requester bit indices (bit0 = player A, bit1 = player B)
//     - GRANT_A/B  : one-hot grant patterns
//     - rr_pick    : round-robin choice between the two requesters
//     - load_value : random value plus base offset, sized to COUNT_W
// -----------------------------------------------------------------------------
package countdown_pkg;

    localparam int unsigned COUNT_W = 6;

    localparam int unsigned REQ_A = 0;
    localparam int unsigned REQ_B = 1;

    localparam logic [1:0] GRANT_A = 2'b01;
    localparam logic [1:0] GRANT_B = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // With both requesters asking, the one not served last wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] req,
                                           input logic [1:0] last_grant);
        logic [1:0] pick;
        pick = '0;
        if (req[REQ_A] && req[REQ_B]) begin
            pick = last_grant[REQ_A] ? GRANT_B : GRANT_A;
        end else if (req[REQ_A]) begin
            pick = GRANT_A;
        end else if (req[REQ_B]) begin
            pick = GRANT_B;
        end
        return pick;
    endfunction

    // BASE + 15 is bounded below 64, so the 6-bit sum never wraps.
    function automatic logic [COUNT_W-1:0] load_value(input logic [3:0]  rand_val,
                                                      input int unsigned base);
        return COUNT_W'(rand_val) + COUNT_W'(base);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Divides the clock down to one tick per TICK_CYCLES enabled cycles.
//   The internal counter runs 0..TICK_CYCLES-1 while enable is high and
//   holds its value while enable is low.
//
//   Ports:
//     clk    in  1  rising-edge clock
//     rst_n  in  1  asynchronous active-low reset
//     clear  in  1  synchronous counter clear (dominates enable)
//     enable in  1  advance the counter this cycle
//     tick   out 1  high on the cycle the counter sits at its terminal value
//                   with enable asserted (the cycle it wraps to 0)
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int unsigned TICK_CYCLES = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             at_terminal;

    assign at_terminal = (cnt_q == TERMINAL);
    assign tick        = enable && at_terminal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            if (at_terminal) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_timer_arbiter.sv
// -----------------------------------------------------------------------------
// countdown_timer_arbiter
//   A single countdown timer shared by two players. A requester wins the
//   timer by round-robin arbitration, the timer is loaded with
//   rand_val + BASE_VALUE seconds and counts down once every TICK_CYCLES
//   clocks. On expiry the owner receives a one-cycle done pulse; the owner
//   may abort its own round with cancel.
//
//   Optional feature macro: COUNTDOWN_PAUSE_EN
//     Adds the pause input; while high in COUNT the countdown freezes.
//     When undefined, the port and the freeze logic do not exist.
//
//   Parameters:
//     TICK_CYCLES  clock cycles per countdown second
//     BASE_VALUE   offset added to rand_val (BASE_VALUE + 15 <= 63)
//
//   Ports:
//     clk          in   1  sole clock, rising edge
//     rst_n        in   1  asynchronous active-low reset
//     req          in   2  level requests, bit0 = A, bit1 = B (sampled in IDLE)
//     cancel       in   2  abort, honoured only on the granted bit
//     rand_val     in   4  random value from external LFSR
//     pause        in   1  freeze countdown (COUNTDOWN_PAUSE_EN only)
//     grant        out  2  one-hot timer owner, zero when idle
//     busy         out  1  high in LOAD, COUNT and DONE
//     count        out  6  remaining seconds, zero outside COUNT
//     start_value  out  6  value latched at LOAD, held until the next LOAD
//     done         out  2  one-cycle expiry pulse to the owner
// -----------------------------------------------------------------------------
module countdown_timer_arbiter
    import countdown_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 100000000,
    parameter int unsigned BASE_VALUE  = 21
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [1:0]         cancel,
    input  logic [3:0]         rand_val,
`ifdef COUNTDOWN_PAUSE_EN
    input  logic               pause,
`endif
    output logic [1:0]         grant,
    output logic               busy,
    output logic [COUNT_W-1:0] count,
    output logic [COUNT_W-1:0] start_value,
    output logic [1:0]         done
);

    state_t             state_q;
    logic [1:0]         grant_q;
    logic [1:0]         last_grant_q;
    logic               busy_q;
    logic [COUNT_W-1:0] timer_q;
    logic [COUNT_W-1:0] start_q;
    logic [1:0]         done_q;

    logic               cancel_hit;
    logic               tick_clear;
    logic               tick_en;
    logic               tick;
    logic [COUNT_W-1:0] load_val;

    // Only the owner's cancel bit counts; grant is zero in IDLE/after DONE.
    assign cancel_hit = |(cancel & grant_q);
    assign load_val   = load_value(rand_val, BASE_VALUE);
    assign tick_clear = (state_q == ST_LOAD);

`ifdef COUNTDOWN_PAUSE_EN
    assign tick_en = (state_q == ST_COUNT) && !pause;
`else
    assign tick_en = (state_q == ST_COUNT);
`endif

    tick_prescaler #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tick_clear),
        .enable (tick_en),
        .tick   (tick)
    );

    // The timer register doubles as the count output: it is loaded on the
    // LOAD edge, stays at zero in every other state, and is cleared on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= GRANT_B;
            busy_q       <= 1'b0;
            timer_q      <= '0;
            start_q      <= '0;
            done_q       <= '0;
        end else begin
            done_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        grant_q <= rr_pick(req, last_grant_q);
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    start_q <= load_val;
                    if (cancel_hit) begin
                        last_grant_q <= grant_q;
                        grant_q      <= '0;
                        busy_q       <= 1'b0;
                        timer_q      <= '0;
                        state_q      <= ST_IDLE;
                    end else begin
                        timer_q <= load_val;
                        state_q <= ST_COUNT;
                    end
                end

                ST_COUNT: begin
                    // Cancel is checked first so it beats a coincident
                    // decrement or expiry.
                    if (cancel_hit) begin
                        last_grant_q <= grant_q;
                        grant_q      <= '0;
                        busy_q       <= 1'b0;
                        timer_q      <= '0;
                        state_q      <= ST_IDLE;
                    end else if (tick) begin
                        if (timer_q <= COUNT_W'(1)) begin
                            timer_q <= '0;
                            done_q  <= grant_q;
                            state_q <= ST_DONE;
                        end else begin
                            timer_q <= timer_q - COUNT_W'(1);
                        end
                    end
                end

                ST_DONE: begin
                    last_grant_q <= grant_q;
                    grant_q      <= '0;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign count       = timer_q;
    assign start_value = start_q;
    assign done        = done_q;

endmodule
